// File: rtl/uart_boot_loader.sv
// uart_boot_loader: pops framed bytes (HEADER, N, N data, checksum) from the
// UART rx FIFO, writes the payload to imem, and releases the CPU on a good frame.
//   clk, reset_n          : clock, async active-low reset
//   rx_empty, r_data      : rx FIFO status and head byte
//   rd_uart               : one-cycle FIFO pop strobe
//   load_req              : re-arm pulse (honoured only in RUN)
//   imem_we/addr/wdata    : registered imem write port
//   cpu_run, load_busy    : CPU run enable, frame in progress
//   load_err              : sticky error, cleared by the next HEADER
module uart_boot_loader #(
  parameter int         ADDR_W  = 8,
  parameter logic [7:0] HEADER  = 8'hA5,
  parameter int         TIMEOUT = 1_000_000
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              rx_empty,
  input  logic [7:0]        r_data,
  output logic              rd_uart,
  input  logic              load_req,
  output logic              imem_we,
  output logic [ADDR_W-1:0] imem_addr,
  output logic [7:0]        imem_wdata,
  output logic              cpu_run,
  output logic              load_busy,
  output logic              load_err
);

  localparam int TW = $clog2(TIMEOUT + 1);

  typedef enum logic [2:0] {
    S_IDLE, S_LEN, S_DATA, S_CSUM, S_RUN
  } state_t;

  state_t            state_q, state_d;
  logic              pop_q;
  logic              pop;
  logic              busy;
  logic              tout;
  logic              err_set;
  logic [7:0]        cnt_q;
  logic [7:0]        sum_q;
  logic [7:0]        sum_nx;
  logic [ADDR_W-1:0] addr_q;
  logic [TW-1:0]     tcnt_q;

  assign busy   = (state_q == S_LEN) || (state_q == S_DATA) ||
                  (state_q == S_CSUM);
  // reset_n gates the strobe so nothing is popped while reset is held
  assign pop    = reset_n && !rx_empty && !pop_q && (state_q != S_RUN);
  assign sum_nx = sum_q + r_data;
  // this cycle would be the TIMEOUT-th consecutive empty one
  assign tout   = busy && rx_empty && (tcnt_q == TW'(TIMEOUT - 1));

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) state_q <= S_IDLE;
    else          state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    err_set = 1'b0;
    unique case (state_q)
      S_IDLE:
        if (pop && r_data == HEADER) state_d = S_LEN;
      S_LEN:
        if (pop) begin
          if (r_data == 8'h00) begin
            state_d = S_IDLE;
            err_set = 1'b1;
          end else begin
            state_d = S_DATA;
          end
        end
      S_DATA:
        if (pop && cnt_q == 8'd1) state_d = S_CSUM;
      S_CSUM:
        if (pop) begin
          if (sum_nx == 8'h00) begin
            state_d = S_RUN;
          end else begin
            state_d = S_IDLE;
            err_set = 1'b1;
          end
        end
      S_RUN:
        if (load_req) state_d = S_IDLE;
      default:
        state_d = S_IDLE;
    endcase
    if (tout) begin
      state_d = S_IDLE;
      err_set = 1'b1;
    end
  end

  always_comb begin
    cpu_run   = (state_q == S_RUN);
    load_busy = busy;
    rd_uart   = pop;
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      pop_q      <= 1'b0;
      cnt_q      <= '0;
      sum_q      <= '0;
      addr_q     <= '0;
      tcnt_q     <= '0;
      imem_we    <= 1'b0;
      imem_addr  <= '0;
      imem_wdata <= '0;
      load_err   <= 1'b0;
    end else begin
      pop_q   <= pop;
      imem_we <= 1'b0;
      if (!busy || pop) tcnt_q <= '0;
      else if (rx_empty) tcnt_q <= tcnt_q + 1'b1;
      if (err_set) load_err <= 1'b1;
      if (pop) begin
        unique case (state_q)
          S_IDLE:
            if (r_data == HEADER) begin
              load_err <= 1'b0;
              sum_q    <= '0;
              addr_q   <= '0;
            end
          S_LEN: begin
            cnt_q <= r_data;
            sum_q <= r_data;
          end
          S_DATA: begin
            imem_we    <= 1'b1;
            imem_addr  <= addr_q;
            imem_wdata <= r_data;
            addr_q     <= addr_q + 1'b1;
            sum_q      <= sum_nx;
            cnt_q      <= cnt_q - 1'b1;
          end
          default: ;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_uart_boot_loader.sv
// tb_uart_boot_loader: directed frames through a FIFO model,
// table-driven plus hand sequences for reload, timeout and reset.
module tb_uart_boot_loader;

  logic       clk = 1'b0;
  logic       reset_n = 1'b0;
  logic       rx_empty = 1'b1;
  logic [7:0] r_data = 8'h00;
  logic       load_req = 1'b0;
  logic       rd_uart;
  logic       imem_we;
  logic [7:0] imem_addr;
  logic [7:0] imem_wdata;
  logic       cpu_run;
  logic       load_busy;
  logic       load_err;

  always #5 clk = ~clk;

  uart_boot_loader #(
    .ADDR_W(8), .HEADER(8'hA5), .TIMEOUT(16)
  ) dut (
    .clk(clk), .reset_n(reset_n),
    .rx_empty(rx_empty), .r_data(r_data), .rd_uart(rd_uart),
    .load_req(load_req),
    .imem_we(imem_we), .imem_addr(imem_addr),
    .imem_wdata(imem_wdata),
    .cpu_run(cpu_run), .load_busy(load_busy),
    .load_err(load_err)
  );

  logic [7:0]  fifo[$];
  logic [15:0] wlog[$];
  int n_cmp = 0;
  int n_bad = 0;
  int cyc = 0;
  int last_pop = 0;
  int run_rise = -1;
  int v_consec = 0;
  int v_runbusy = 0;
  bit pend = 1'b0;
  bit prev_rd = 1'b0;
  bit run_prev = 1'b0;

  always @(posedge clk) begin
    cyc     <= cyc + 1;
    pend    <= rd_uart;
    prev_rd <= rd_uart;
    if (rd_uart) last_pop <= cyc;
    if (rd_uart && prev_rd) v_consec <= v_consec + 1;
  end

  always @(negedge clk) begin
    if (pend && fifo.size() > 0) fifo.delete(0);
    rx_empty = (fifo.size() == 0);
    r_data   = rx_empty ? 8'h00 : fifo[0];
    if (imem_we) wlog.push_back({imem_addr, imem_wdata});
    if (cpu_run && !run_prev) run_rise = cyc;
    run_prev = cpu_run;
    if (cpu_run && load_busy) v_runbusy++;
  end

  task automatic check(string name, logic [31:0] act, logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h want %0h", name, act, exp);
    end
  endtask

  task automatic push(logic [63:0] b, int nb);
    for (int i = 0; i < nb; i++) fifo.push_back(b[63-8*i -: 8]);
  endtask

  task automatic drain(string name);
    int k = 0;
    while (fifo.size() != 0 && k < 300) begin
      @(negedge clk);
      k++;
    end
    check({name, " drain"}, 32'(fifo.size() == 0), 32'd1);
  endtask

  task automatic rearm();
    if (cpu_run) begin
      @(negedge clk) load_req = 1'b1;
      @(negedge clk) load_req = 1'b0;
    end
  endtask

  task automatic check_reset(string name);
    check({name, " rd"},    32'(rd_uart),    32'd0);
    check({name, " we"},    32'(imem_we),    32'd0);
    check({name, " addr"},  32'(imem_addr),  32'd0);
    check({name, " wdata"}, 32'(imem_wdata), 32'd0);
    check({name, " run"},   32'(cpu_run),    32'd0);
    check({name, " busy"},  32'(load_busy),  32'd0);
    check({name, " err"},   32'(load_err),   32'd0);
  endtask

  typedef struct packed {
    logic [63:0] b;
    logic [3:0]  nb;
    logic [63:0] w;
    logic [2:0]  nw;
    logic        run;
    logic        err;
  } vec_t;

  vec_t vt[6];

  initial begin
    // bytes MSB-first; writes {addr,data} MSB-first
    vt[0] = '{64'hA5_03_11_22_33_97_00_00, 4'd6,
              64'h0011_0122_0233_0000, 3'd3, 1'b1, 1'b0};
    vt[1] = '{64'hA5_02_A5_10_49_00_00_00, 4'd5,
              64'h00A5_0110_0000_0000, 3'd2, 1'b1, 1'b0};
    vt[2] = '{64'h00_FF_A5_03_11_22_33_97, 4'd8,
              64'h0011_0122_0233_0000, 3'd3, 1'b1, 1'b0};
    vt[3] = '{64'hA5_02_10_20_00_00_00_00, 4'd5,
              64'h0010_0120_0000_0000, 3'd2, 1'b0, 1'b1};
    vt[4] = '{64'hA5_00_00_00_00_00_00_00, 4'd2,
              64'h0, 3'd0, 1'b0, 1'b1};
    vt[5] = '{64'hA5_01_7F_80_00_00_00_00, 4'd4,
              64'h007F_0000_0000_0000, 3'd1, 1'b1, 1'b0};

    repeat (3) @(negedge clk);
    check_reset("reset");
    reset_n = 1'b1;
    @(negedge clk);

    for (int i = 0; i < 6; i++) begin
      string nm;
      nm = $sformatf("vec%0d", i);
      rearm();
      wlog.delete();
      run_rise = -1;
      push(vt[i].b, int'(vt[i].nb));
      drain(nm);
      repeat (4) @(negedge clk);
      check({nm, " nwr"}, 32'(wlog.size()), 32'(vt[i].nw));
      for (int j = 0; j < int'(vt[i].nw); j++)
        if (j < wlog.size())
          check($sformatf("%s wr%0d", nm, j), 32'(wlog[j]),
                32'(vt[i].w[63-16*j -: 16]));
      check({nm, " run"}, 32'(cpu_run), 32'(vt[i].run));
      check({nm, " err"}, 32'(load_err), 32'(vt[i].err));
      if (vt[i].run)
        check({nm, " run_lat"}, 32'(run_rise - last_pop), 32'd1);
    end

    // reload from RUN: bytes wait untouched until load_req
    wlog.delete();
    push(64'hA5_01_05_FA_00_00_00_00, 4);
    repeat (5) @(negedge clk);
    check("run_hold fifo", 32'(fifo.size()), 32'd4);
    @(negedge clk) load_req = 1'b1;
    @(negedge clk) load_req = 1'b0;
    check("reload run_drop", 32'(cpu_run), 32'd0);
    drain("reload");
    repeat (4) @(negedge clk);
    check("reload nwr", 32'(wlog.size()), 32'd1);
    if (wlog.size() > 0) check("reload wr0", 32'(wlog[0]), 32'h0005);
    check("reload run", 32'(cpu_run), 32'd1);

    // timeout mid-DATA
    rearm();
    wlog.delete();
    push(64'hA5_02_10_00_00_00_00_00, 3);
    drain("tout");
    repeat (6) @(negedge clk);
    check("tout early busy", 32'(load_busy), 32'd1);
    check("tout early err", 32'(load_err), 32'd0);
    repeat (20) @(negedge clk);
    check("tout err", 32'(load_err), 32'd1);
    check("tout busy", 32'(load_busy), 32'd0);
    check("tout run", 32'(cpu_run), 32'd0);
    check("tout nwr", 32'(wlog.size()), 32'd1);
    if (wlog.size() > 0) check("tout wr0", 32'(wlog[0]), 32'h0010);

    // reset in the middle of DATA
    push(64'hA5_04_01_02_00_00_00_00, 4);
    drain("rst");
    repeat (2) @(negedge clk);
    check("rst pre busy", 32'(load_busy), 32'd1);
    check("rst pre addr", 32'(imem_addr), 32'd1);
    #2 reset_n = 1'b0;
    #1 check_reset("rst mid");
    @(negedge clk);
    @(negedge clk) reset_n = 1'b1;
    wlog.delete();
    repeat (30) @(negedge clk);
    check("rst no_wr", 32'(wlog.size()), 32'd0);
    push(64'hA5_01_05_FA_00_00_00_00, 4);
    drain("rst frame");
    repeat (4) @(negedge clk);
    check("rst frame nwr", 32'(wlog.size()), 32'd1);
    check("rst frame run", 32'(cpu_run), 32'd1);

    check("pop spacing", 32'(v_consec), 32'd0);
    check("run vs busy", 32'(v_runbusy), 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
